// File: rtl/traffic_phase_ctrl.sv
// N-phase round-robin signal controller with demand skipping, emergency preemption and cycle counting.
// Optional build macro TRAFFIC_GREEN_EXT_EN: hold GREEN indefinitely while no other phase is waiting.
module traffic_phase_ctrl #(
  parameter int NUM_PH   = 4,
  parameter int PW       = $clog2(NUM_PH),
  parameter int TW       = 16,
  parameter int GREEN_T  = 20,
  parameter int YELLOW_T = 4,
  parameter int ALLRED_T = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_en,
  input  logic [NUM_PH-1:0] demand,
  input  logic              emerg_req,
  input  logic [PW-1:0]     emerg_phase,
  output logic [NUM_PH-1:0] green,
  output logic [NUM_PH-1:0] yellow,
  output logic [NUM_PH-1:0] red,
  output logic [PW-1:0]     active_phase,
  output logic [1:0]        state,
  output logic              cycle_tick,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_EMERG  = 2'd3
  } state_t;

  localparam logic [TW-1:0] T_GREEN  = TW'(GREEN_T);
  localparam logic [TW-1:0] T_YELLOW = TW'(YELLOW_T);
  localparam logic [TW-1:0] T_ALLRED = TW'(ALLRED_T);

  state_t            st, nxt_st;
  logic [NUM_PH-1:0] dem_s1, dem_s2, dem_lat, clr;
  logic              emg_s1, emg_s2;
  logic [TW-1:0]     timer, nxt_timer;
  logic [PW-1:0]     last, nxt_last, nxt_act;
  logic [PW-1:0]     sel_phase, idx, emg_ph_ok;
  logic              sel_found, served, nxt_served, nxt_tick, expire;

  assign state     = st;
  assign expire    = tick_en && (timer == TW'(1));
  assign emg_ph_ok = (int'(emerg_phase) < NUM_PH) ? emerg_phase : '0;

  function automatic logic [NUM_PH-1:0] onehot(input logic [PW-1:0] p);
    return NUM_PH'(1) << p;
  endfunction

`ifdef TRAFFIC_GREEN_EXT_EN
  logic others_pending;
  assign others_pending = |(dem_lat & ~onehot(active_phase));
`endif

  // Round-robin search starting just after the last served phase.
  always_comb begin
    sel_found = 1'b0;
    sel_phase = '0;
    idx       = '0;
    for (int k = 1; k <= NUM_PH; k++) begin
      idx = PW'((int'(last) + k) % NUM_PH);
      if (!sel_found && dem_lat[idx]) begin
        sel_found = 1'b1;
        sel_phase = idx;
      end
    end
  end

  always_comb begin
    nxt_st     = st;
    nxt_timer  = timer;
    nxt_act    = active_phase;
    nxt_last   = last;
    nxt_served = served;
    nxt_tick   = 1'b0;
    clr        = '0;
    case (st)
      ST_ALLRED: begin
        if (expire) begin
          if (emg_s2) begin
            nxt_st  = ST_EMERG;
            nxt_act = emg_ph_ok;
          end else begin
            nxt_st     = ST_GREEN;
            nxt_timer  = T_GREEN;
            nxt_act    = sel_found ? sel_phase : '0;
            nxt_last   = nxt_act;
            nxt_served = 1'b1;
            // A wrap only counts once some phase has been served since reset.
            nxt_tick   = served && (nxt_act <= last);
            clr        = onehot(nxt_act);
          end
        end else if (tick_en) begin
          nxt_timer = timer - TW'(1);
        end
      end
      ST_GREEN: begin
        if (emg_s2) begin
          if (active_phase == emerg_phase) begin
            nxt_st = ST_EMERG;
          end else begin
            nxt_st    = ST_YELLOW;
            nxt_timer = T_YELLOW;
          end
        end else if (expire) begin
`ifdef TRAFFIC_GREEN_EXT_EN
          if (!others_pending) begin
            nxt_timer = T_GREEN;
          end else begin
            nxt_st    = ST_YELLOW;
            nxt_timer = T_YELLOW;
          end
`else
          nxt_st    = ST_YELLOW;
          nxt_timer = T_YELLOW;
`endif
        end else if (tick_en) begin
          nxt_timer = timer - TW'(1);
        end
      end
      ST_YELLOW: begin
        if (expire) begin
          nxt_st    = ST_ALLRED;
          nxt_timer = T_ALLRED;
        end else if (tick_en) begin
          nxt_timer = timer - TW'(1);
        end
      end
      ST_EMERG: begin
        if (!emg_s2) begin
          nxt_st     = ST_YELLOW;
          nxt_timer  = T_YELLOW;
          nxt_last   = active_phase;
          nxt_served = 1'b1;
        end
      end
      default: begin
        nxt_st    = ST_ALLRED;
        nxt_timer = T_ALLRED;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= ST_ALLRED;
      timer        <= T_ALLRED;
      active_phase <= '0;
      last         <= PW'(NUM_PH - 1);
      served       <= 1'b0;
      dem_s1       <= '0;
      dem_s2       <= '0;
      dem_lat      <= '0;
      emg_s1       <= 1'b0;
      emg_s2       <= 1'b0;
      green        <= '0;
      yellow       <= '0;
      red          <= '1;
      cycle_tick   <= 1'b0;
      cycle_count  <= '0;
    end else begin
      dem_s1       <= demand;
      dem_s2       <= dem_s1;
      emg_s1       <= emerg_req;
      emg_s2       <= emg_s1;
      dem_lat      <= (dem_lat | dem_s2) & ~clr;
      st           <= nxt_st;
      timer        <= nxt_timer;
      active_phase <= nxt_act;
      last         <= nxt_last;
      served       <= nxt_served;
      green        <= (nxt_st == ST_GREEN || nxt_st == ST_EMERG) ? onehot(nxt_act) : '0;
      yellow       <= (nxt_st == ST_YELLOW) ? onehot(nxt_act) : '0;
      red          <= (nxt_st == ST_ALLRED) ? '1 : ~onehot(nxt_act);
      cycle_tick   <= nxt_tick;
      if (nxt_tick && cycle_count != '1)
        cycle_count <= cycle_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Parametrised N-approach intersection controller. It is the next-generation successor of the fixed two-road sequencer top. A single registered FSM serves NUM_PH signal phases in round-robin order and skips phases with no latched vehicle demand. It handles emergency preemption to a selectable phase and counts completed service cycles. It sits between the debounced field inputs and the lamp drivers, and replaces the separate FSM, timer and cycle-counter glue.

## Interface
- NUM_PH, 4: number of phases, 2..8; phase 0 is the main road.
- PW, $clog2(NUM_PH): phase index width.
- TW, 16: timer width.
- GREEN_T, 20: green duration in tick_en pulses, ≥1.
- YELLOW_T, 4: yellow duration, ≥1.
- ALLRED_T, 2: all-red clearance duration, ≥1.
- CNT_W, 16: cycle counter width.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- tick_en  in  1  one-clk time-base strobe; all timers advance only on it.
- demand  in  NUM_PH  raw per-phase vehicle sensors; asynchronous.
- emerg_req  in  1  emergency request, level; asynchronous.
- emerg_phase  in  PW  phase granted green during emergency.
- green / yellow / red  out  NUM_PH each  one-hot-per-phase lamp outputs.
- active_phase  out  PW  phase currently owning green/yellow.
- state  out  2  0=ALLRED, 1=GREEN, 2=YELLOW, 3=EMERG.
- cycle_tick  out  1  one-clk pulse per completed cycle.
- cycle_count  out  CNT_W  saturating cycle count.

## Operation
- demand and emerg_req each pass through a 2-flop synchronizer.
- Per-phase sticky demand latch. It sets on a synchronized demand bit and clears on the edge its phase enters GREEN. If set and clear occur together for the active phase, clear wins.
- Timer: loaded with the state duration on every state entry. It decrements on tick_en. A state exits on the clk edge where tick_en=1 and timer==1.
- ALLRED expiry selects the next phase:
  - Emergency pending: go to EMERG.
  - Otherwise: the first phase with its latch set, searching from (last_served+1) mod NUM_PH upward with wrap.
  - No latch set: phase 0 (rest on main).
  - Enter GREEN.
- GREEN expiry: enter YELLOW with the same phase.
- YELLOW expiry: enter ALLRED. active_phase holds its last value.
- Lamps:
  - GREEN: green[active_phase]=1, all other reds=1.
  - YELLOW: yellow[active_phase]=1, all other reds=1.
  - ALLRED: all red.
  - EMERG: green[captured emergency phase]=1, all other reds=1.
- Emergency (synchronized emerg_req=1):
  - In GREEN with active_phase≠emerg_phase: go to YELLOW immediately, timer reloaded.
  - In GREEN with active_phase==emerg_phase: go to EMERG the next edge.
  - In YELLOW or ALLRED: complete normally, then enter EMERG.
  - On EMERG entry, emerg_phase is captured. If emerg_phase ≥ NUM_PH, phase 0 is used.
  - EMERG holds while the request stays high. On release: YELLOW (captured phase), then ALLRED, then normal selection with last_served = captured phase.
- cycle_tick fires on a normal GREEN entry whose phase ≤ last_served phase (round-robin wrap). EMERG never ticks.
- cycle_count increments on cycle_tick and saturates at all-ones.

## Timing
- Reset values:
  - state=ALLRED, timer=ALLRED_T, active_phase=0, last_served=NUM_PH-1.
  - All demand latches clear.
  - red=all ones; green and yellow=0.
  - cycle_tick=0, cycle_count=0.
- All outputs are registered and change on the same edge as state.
- External demand becomes latch-visible 3 clk after its edge: 2 sync flops plus the latch.
- emerg_req reaches the FSM after 2 clk.
- A state lasts exactly DUR tick_en pulses. The first pulse counts only if it arrives the cycle after entry or later.
- Reset asserted mid-operation returns to reset values asynchronously. The first ALLRED then runs its full duration.

## Configuration
- TRAFFIC_GREEN_EXT_EN defined: at GREEN expiry with no other phase's latch set (and no emergency pending), stay in GREEN and reload the timer (indefinite extension).
- TRAFFIC_GREEN_EXT_EN undefined: GREEN always ends at expiry. If no other demand exists, the same phase re-serves after YELLOW and ALLRED.

## Test plan
- Reset, no demand, tick_en every cycle, defaults: sequence ALLRED(2), then phase 0 GREEN(20), YELLOW(4), ALLRED(2), repeated. cycle_tick on each phase-0 GREEN entry after the first. With TRAFFIC_GREEN_EXT_EN defined, phase 0 stays green.
- Demand pulses on phases 2 and 1 during phase 0 GREEN: next greens are 1 then 2 and phase 3 is skipped. cycle_count=1 on the return to phase 0.
- emerg_req=1 with emerg_phase=3 during phase 1 GREEN at timer=15: YELLOW immediately, then ALLRED(2), EMERG with green[3]. On release: YELLOW(3), ALLRED, next green selected from phase 0 upward.
- emerg_phase=2 while phase 2 is already green: EMERG entered with no yellow and green[2] continuous.
- Set CNT_W=2 and force 5 cycles: cycle_count stays at 3.
- Assert rst mid-YELLOW: all outputs return to reset values the same cycle, demand latches are cleared, and the controller restarts from ALLRED.
